// File: rtl/prng_pkg.sv
// prng_pkg: default LFSR constants and feedback reduction shared by the PRNG block
package prng_pkg;
    localparam logic [31:0] DEF_TAPS = 32'h088C_8892;
    localparam logic [31:0] DEF_SEED = 32'h00B4_1AFD;

    function automatic logic fb_xor(input logic [63:0] state, input logic [63:0] taps);
        return ^(state & taps);
    endfunction
endpackage

// File: rtl/lfsr_core.sv
// lfsr_core: Fibonacci LFSR state with seed substitution and all-zero lock-up recovery
module lfsr_core
    import prng_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter logic [WIDTH-1:0] TAPS = WIDTH'(DEF_TAPS),
    parameter logic [WIDTH-1:0] SEED = WIDTH'(DEF_SEED)
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic             go_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] seed_i,
    output logic [WIDTH-1:0] state_o,
    output logic             fb_o,
    output logic             adv_o,
    output logic             lockup_o
);
    logic             zero;
    logic             rec;
    logic [WIDTH-1:0] state_n;

    assign fb_o  = fb_xor(64'(state_o), 64'(TAPS));
    assign zero  = state_o == '0;
    assign adv_o = go_i && !load_i && !zero;
    assign rec   = go_i && !load_i && zero;

    // a zero seed would lock the register, so it is replaced by SEED
    always_comb state_n = load_i ? (seed_i == '0 ? SEED : seed_i) :
                          rec    ? SEED :
                          adv_o  ? {state_o[WIDTH-2:0], fb_o} : state_o;

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_o  <= SEED;
            lockup_o <= 1'b0;
        end else begin
            state_o  <= state_n;
            lockup_o <= rec;
        end
    end
endmodule

// File: rtl/prng_lfsr.sv
// prng_lfsr: LFSR random word generator with valid/ready output handshake
module prng_lfsr
    import prng_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter logic [WIDTH-1:0] TAPS = WIDTH'(DEF_TAPS),
    parameter logic [WIDTH-1:0] SEED = WIDTH'(DEF_SEED),
    parameter int OUT_W = 8
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic             enable_i,
    input  logic             seed_valid_i,
    input  logic [WIDTH-1:0] seed_i,
    input  logic             ready_i,
    output logic             valid_o,
    output logic [OUT_W-1:0] data_o,
    output logic [WIDTH-1:0] state_o,
    output logic             lockup_o
);
    localparam int CW = OUT_W > 1 ? $clog2(OUT_W) : 1;
    localparam logic [CW-1:0] CMAX = CW'(OUT_W - 1);

    logic [CW-1:0]    cnt;
    logic [OUT_W-1:0] word;
    logic [OUT_W-1:0] word_n;
    logic             go;
    logic             fb;
    logic             adv;
    logic             done;

    // a pending unaccepted word stalls the LFSR
    assign go     = enable_i && (!valid_o || ready_i);
    assign word_n = OUT_W'({word, fb});
    assign done   = adv && cnt == CMAX;

    lfsr_core #(
        .WIDTH(WIDTH),
        .TAPS (TAPS),
        .SEED (SEED)
    ) core (
        .clk_i   (clk_i),
        .reset_ni(reset_ni),
        .go_i    (go),
        .load_i  (seed_valid_i),
        .seed_i  (seed_i),
        .state_o (state_o),
        .fb_o    (fb),
        .adv_o   (adv),
        .lockup_o(lockup_o)
    );

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            cnt     <= '0;
            word    <= '0;
            data_o  <= '0;
            valid_o <= 1'b0;
        end else if (seed_valid_i) begin
            cnt     <= '0;
            word    <= '0;
            valid_o <= 1'b0;
        end else begin
            if (adv) begin
                cnt  <= done ? '0 : cnt + CW'(1);
                word <= word_n;
            end
            if (done) data_o <= word_n;
            valid_o <= done || (valid_o && !ready_i);
        end
    end
endmodule

// File: tb/tb_prng_lfsr.sv
// tb_prng_lfsr: scoreboard bench for prng_lfsr (OUT_W=8 main instance, OUT_W=1 streaming instance)
module tb_prng_lfsr;
    localparam logic [31:0] TAPS = 32'h088C_8892;
    localparam logic [31:0] SEED = 32'h00B4_1AFD;

    logic        clk = 1'b0, reset_ni = 1'b0, enable = 1'b0, seed_valid = 1'b0, ready = 1'b0, en1 = 1'b0;
    logic [31:0] seed = '0;
    logic        valid, lockup, valid1, lockup1;
    logic [7:0]  data;
    logic [0:0]  data1;
    logic [31:0] state, state1;
    logic [31:0] m, s0;
    logic [7:0]  d0;
    logic [7:0]  q[$];
    logic        q1[$];
    int          checks = 0, failures = 0, n;

    always #5 clk = ~clk;

    prng_lfsr dut (
        .clk_i(clk), .reset_ni(reset_ni), .enable_i(enable), .seed_valid_i(seed_valid),
        .seed_i(seed), .ready_i(ready), .valid_o(valid), .data_o(data),
        .state_o(state), .lockup_o(lockup)
    );

    prng_lfsr #(.OUT_W(1)) dut1 (
        .clk_i(clk), .reset_ni(reset_ni), .enable_i(en1), .seed_valid_i(1'b0),
        .seed_i(32'h0), .ready_i(1'b1), .valid_o(valid1), .data_o(data1),
        .state_o(state1), .lockup_o(lockup1)
    );

    function automatic logic [31:0] step(input logic [31:0] s);
        return {s[30:0], ^(s & TAPS)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic push_word();
        logic [7:0] w = '0;
        for (int i = 0; i < 8; i++) begin
            w = {w[6:0], ^(m & TAPS)};
            m = step(m);
        end
        q.push_back(w);
    endtask

    task automatic wait_valid(input string name);
        n = 0;
        while (!valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check(name, n, 8);
    endtask

    // monitor: every accepted word is popped from the scoreboard and compared
    always begin
        @(negedge clk);
        #1;
        if (reset_ni && valid && ready && !seed_valid) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_word actual=%h required=none", data);
            end else check("word", data, q.pop_front());
        end
        if (reset_ni && valid1) begin
            if (q1.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_bit actual=%h required=none", data1);
            end else check("bit", data1, q1.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        check("rst_state", state, SEED);
        check("rst_valid", valid, 0);
        check("rst_data", data, 0);
        check("rst_lockup", lockup, 0);
        reset_ni = 1'b1;

        m = SEED;
        for (int i = 0; i < 12; i++) begin
            q1.push_back(^(m & TAPS));
            m = step(m);
        end
        en1 = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("w1_valid", valid1, 1);
        end
        en1 = 1'b0;
        @(negedge clk);
        check("w1_state", state1, m);
        check("w1_idle", valid1, 0);

        m = SEED;
        repeat (4) push_word();
        enable = 1'b1;
        ready  = 1'b1;
        @(negedge clk);
        check("first_step", state, 32'h0168_35FB);
        n = 1;
        while (!valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("first_valid_latency", n, 8);
        repeat (24) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        check("run_state", state, m);
        check("run_idle", valid, 0);

        seed = 32'h1234_5678;
        seed_valid = 1'b1;
        @(negedge clk);
        seed_valid = 1'b0;
        check("seed_load", state, 32'h1234_5678);
        m = 32'h1234_5678;
        push_word();
        enable = 1'b1;
        ready  = 1'b0;
        wait_valid("stall_latency");
        s0 = state;
        d0 = data;
        repeat (5) begin
            @(negedge clk);
            check("stall_state", state, s0);
            check("stall_data", data, d0);
            check("stall_valid", valid, 1);
        end
        ready = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        check("resume_valid", valid, 0);
        check("resume_state", state, step(m));

        seed = 32'h0;
        seed_valid = 1'b1;
        @(negedge clk);
        seed_valid = 1'b0;
        check("zero_seed", state, SEED);
        enable = 1'b1;
        ready  = 1'b0;
        wait_valid("seed_pend_latency");
        enable = 1'b0;
        ready = 1'b1;
        seed = 32'h1;
        seed_valid = 1'b1;
        @(negedge clk);
        seed_valid = 1'b0;
        check("seed_over_valid", valid, 0);
        check("seed_over_state", state, 32'h1);

        seed = 32'h8000_0000;
        seed_valid = 1'b1;
        @(negedge clk);
        seed_valid = 1'b0;
        enable = 1'b1;
        @(negedge clk);
        check("to_zero_state", state, 32'h0);
        check("to_zero_lockup", lockup, 0);
        @(negedge clk);
        check("recover_state", state, SEED);
        check("recover_lockup", lockup, 1);
        @(negedge clk);
        check("after_lockup", lockup, 0);
        check("after_state", state, 32'h0168_35FB);

        repeat (3) @(negedge clk);
        enable = 1'b0;
        reset_ni = 1'b0;
        @(negedge clk);
        reset_ni = 1'b1;
        check("midrst_valid", valid, 0);
        check("midrst_data", data, 0);
        check("midrst_state", state, SEED);
        m = SEED;
        push_word();
        enable = 1'b1;
        repeat (8) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        check("midrst_idle", valid, 0);

        check("queue_empty", q.size(), 0);
        check("queue1_empty", q1.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/prng_lfsr.md
PRNG_LFSR -- requirements
Module: prng_lfsr

Interface
REQ-001 Parameter WIDTH, default 32: LFSR state width; SHALL be 3..64.
REQ-002 Parameter TAPS, default 32'h088C_8892: feedback tap mask of WIDTH bits; SHALL be nonzero.
REQ-003 Parameter SEED, default 32'h00B4_1AFD: reset, zero-substitution and recovery seed of WIDTH bits; SHALL be nonzero.
REQ-004 Parameter OUT_W, default 8: output word width; SHALL be 1..WIDTH.
REQ-005 clk_i  in  1  sole clock; all state updates on the rising edge.
REQ-006 reset_ni  in  1  reset, synchronous and active-low.
REQ-007 enable_i  in  1  advance permission.
REQ-008 seed_valid_i  in  1  one-cycle seed load strobe.
REQ-009 seed_i  in  WIDTH  seed value, sampled when seed_valid_i=1.
REQ-010 ready_i  in  1  consumer accepts data_o.
REQ-011 valid_o  out  1  data_o holds a complete, unconsumed word.
REQ-012 data_o  out  OUT_W  random word.
REQ-013 state_o  out  WIDTH  current LFSR state, registered.
REQ-014 lockup_o  out  1  one-cycle pulse on all-zero recovery.

Function
REQ-015 Feedback bit fb = XOR-reduction of (state & TAPS); next state = {state[WIDTH-2:0], fb}.
REQ-016 An advance occurs in a cycle iff enable_i=1, seed_valid_i=0, state!=0 and (valid_o=0 or ready_i=1).
REQ-017 On each advance, fb is shifted into the LSB of an internal OUT_W-bit word register and a bit counter (0..OUT_W-1) increments; the first generated bit ends at data_o[OUT_W-1].
REQ-018 An advance with counter=OUT_W-1 completes a word: the next cycle has data_o = completed word, valid_o=1 and counter=0.
REQ-019 Handshake: a transfer occurs when valid_o=1 and ready_i=1; valid_o deasserts next cycle unless a word completes in the same cycle (only possible for OUT_W=1), in which case valid_o stays 1 with the new word.
REQ-020 While valid_o=1 and ready_i=0: state, counter and data_o SHALL hold (back-pressure stalls the LFSR).
REQ-021 With enable_i=0: state and counter hold; a pending word remains transferable.
REQ-022 Seed load (seed_valid_i=1) has priority over advance, lock-up recovery and handshake: state <= seed_i, or SEED if seed_i=0; counter and word register cleared; valid_o <= 0; a coincident ready_i is ignored.
REQ-023 Lock-up: if state=0 with seed_valid_i=0, enable_i=1 and (valid_o=0 or ready_i=1), state <= SEED and lockup_o=1 for the next cycle only; counter and word register are unchanged; no bit is generated.
REQ-024 lockup_o SHALL be 0 in every cycle not immediately following a recovery.

Reset
REQ-025 While reset_ni=0 at a clock edge: state=SEED, counter=0, word register=0, data_o=0, valid_o=0, lockup_o=0.
REQ-026 Reset mid-word or mid-handshake SHALL discard the partial or pending word with no output.

Structure
REQ-027 Package prng_pkg SHALL hold the default TAPS and SEED constants and the feedback XOR-reduction function.
REQ-028 Sub-module lfsr_core (state register, feedback, seed substitution, lock-up recovery) SHALL be instantiated by prng_lfsr; prng_lfsr owns word assembly and the handshake.

Verification (defaults unless noted)
REQ-029 Reset held for 2 cycles -> state_o=0x00B41AFD, valid_o=0, data_o=0, lockup_o=0.
REQ-030 enable_i=1, ready_i=1, one advance -> state_o=0x016835FB; first valid_o rises exactly 8 cycles after enable_i rises; data_o matches the reference-model bit sequence.
REQ-031 Word complete, ready_i=0 for 5 cycles -> state_o, data_o stable and valid_o=1 throughout; ready_i=1 -> transfer and LFSR advance resume the same cycle.
REQ-032 seed_valid_i=1 with seed_i=0 -> state_o=0x00B41AFD; with seed_i=0x00000001 while valid_o=1 and ready_i=1 -> valid_o=0 next cycle, state_o=0x00000001.
REQ-033 Load seed_i=0x80000000, enable_i=1 -> state_o=0x00000000 after one advance; next cycle state_o=0x00B41AFD with lockup_o=1 for exactly one cycle.
REQ-034 OUT_W=1 with ready_i=1 held -> valid_o stays 1 continuously, one new bit per cycle.
